// File: rtl/i2s_adc_rx.sv
// i2s_adc_rx: deserializes the WM8731 left-justified, MSB-first stereo ADC stream
// into MSB-aligned output word pairs presented through a valid/ready handshake.
module i2s_adc_rx #(
   parameter int DATA_WIDTH = 24,
   parameter int OUT_WIDTH  = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 enable_i,
   input  logic                 i2s_bclk_i,
   input  logic                 i2s_lrclk_i,
   input  logic                 i2s_adcdat_i,
   output logic [OUT_WIDTH-1:0] sample_left_o,
   output logic [OUT_WIDTH-1:0] sample_right_o,
   output logic                 sample_valid_o,
   input  logic                 sample_ready_i,
   output logic                 overflow_o,
   output logic                 frame_err_o,
   input  logic                 clear_flags_i
);

   localparam int CNT_W = $clog2(DATA_WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   localparam logic [1:0] ST_WAIT_SYNC = 2'd0;
   localparam logic [1:0] ST_LEFT      = 2'd1;
   localparam logic [1:0] ST_RIGHT     = 2'd2;

   logic [1:0]            state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [DATA_WIDTH-1:0] left_hold_q, left_hold_d;
   logic                  left_ok_q, left_ok_d;
   logic                  bclk_q, lrclk_q;

   logic [OUT_WIDTH-1:0]  left_out_q, left_out_d;
   logic [OUT_WIDTH-1:0]  right_out_q, right_out_d;
   logic                  valid_q, valid_d;
   logic                  overflow_q, overflow_d;
   logic                  frame_err_q, frame_err_d;

   logic                  bclk_rise_s, lr_rise_s, lr_fall_s;
   logic                  pair_done_s, ferr_set_s, ovf_set_s;
   logic [OUT_WIDTH-1:0]  left_word_s, right_word_s;

   assign bclk_rise_s = i2s_bclk_i & ~bclk_q;
   assign lr_rise_s   = i2s_lrclk_i & ~lrclk_q;
   assign lr_fall_s   = ~i2s_lrclk_i & lrclk_q;

   // Capture FSM: lrclk edges close a channel before a coincident bclk bit opens the next.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      shift_d     = shift_q;
      left_hold_d = left_hold_q;
      left_ok_d   = left_ok_q;
      pair_done_s = 1'b0;
      ferr_set_s  = 1'b0;
      if (!enable_i) begin
         state_d = ST_WAIT_SYNC;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_WAIT_SYNC: begin
               if (lr_rise_s) begin
                  state_d = ST_LEFT;
                  cnt_d   = '0;
               end else begin
                  state_d = ST_WAIT_SYNC;
               end
            end
            ST_LEFT: begin
               if (lr_fall_s) begin
                  if (cnt_q == CNT_FULL) begin
                     left_hold_d = shift_q;
                     left_ok_d   = 1'b1;
                  end else begin
                     left_ok_d  = 1'b0;
                     ferr_set_s = 1'b1;
                  end
                  state_d = ST_RIGHT;
                  cnt_d   = '0;
               end else begin
                  state_d = ST_LEFT;
               end
            end
            ST_RIGHT: begin
               if (lr_rise_s) begin
                  if (cnt_q != CNT_FULL) begin
                     ferr_set_s = 1'b1;
                  end else if (left_ok_q) begin
                     pair_done_s = 1'b1;
                  end else begin
                     pair_done_s = 1'b0;
                  end
                  state_d = ST_LEFT;
                  cnt_d   = '0;
               end else begin
                  state_d = ST_RIGHT;
               end
            end
            default: begin
               state_d = ST_WAIT_SYNC;
               cnt_d   = '0;
            end
         endcase
         // Bits beyond DATA_WIDTH in a half-frame are dropped.
         if (bclk_rise_s && (state_d != ST_WAIT_SYNC) && (cnt_d < CNT_FULL)) begin
            shift_d = (shift_q << 1) | DATA_WIDTH'(i2s_adcdat_i);
            cnt_d   = cnt_d + CNT_ONE;
         end else begin
            shift_d = shift_q;
         end
      end
   end

   // MSB-align the captured channels into output words with zeroed low bits.
   always_comb begin
      left_word_s  = '0;
      right_word_s = '0;
      left_word_s[OUT_WIDTH-1 -: DATA_WIDTH]  = left_hold_q;
      right_word_s[OUT_WIDTH-1 -: DATA_WIDTH] = shift_q;
   end

   // Output pair register: a new pair is dropped when the held one is neither consumed nor replaced.
   always_comb begin
      left_out_d  = left_out_q;
      right_out_d = right_out_q;
      valid_d     = valid_q;
      ovf_set_s   = 1'b0;
      if (pair_done_s) begin
         if (!valid_q || sample_ready_i) begin
            left_out_d  = left_word_s;
            right_out_d = right_word_s;
            valid_d     = 1'b1;
         end else begin
            ovf_set_s = 1'b1;
         end
      end else if (valid_q && sample_ready_i) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
      overflow_d  = ovf_set_s | (overflow_q & ~clear_flags_i);
      frame_err_d = ferr_set_s | (frame_err_q & ~clear_flags_i);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= ST_WAIT_SYNC;
         cnt_q       <= '0;
         shift_q     <= '0;
         left_hold_q <= '0;
         left_ok_q   <= 1'b0;
         bclk_q      <= 1'b0;
         lrclk_q     <= 1'b0;
         left_out_q  <= '0;
         right_out_q <= '0;
         valid_q     <= 1'b0;
         overflow_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         shift_q     <= shift_d;
         left_hold_q <= left_hold_d;
         left_ok_q   <= left_ok_d;
         bclk_q      <= i2s_bclk_i;
         lrclk_q     <= i2s_lrclk_i;
         left_out_q  <= left_out_d;
         right_out_q <= right_out_d;
         valid_q     <= valid_d;
         overflow_q  <= overflow_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign sample_left_o  = left_out_q;
   assign sample_right_o = right_out_q;
   assign sample_valid_o = valid_q;
   assign overflow_o     = overflow_q;
   assign frame_err_o    = frame_err_q;

endmodule

// File: tb/tb_i2s_adc_rx.sv
// tb_i2s_adc_rx: directed bench for i2s_adc_rx; bclk/lrclk are generated cycle by
// cycle with the clk/32 and clk/1536 ratios of the top-level dividers.
module tb_i2s_adc_rx;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b1;
   logic        bclk = 1'b0;
   logic        lrclk = 1'b0;
   logic        adcdat = 1'b0;
   logic        ready = 1'b0;
   logic        clear = 1'b0;
   logic [31:0] left, right;
   logic        valid, ovf, ferr;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int acc_n = 0;
   logic [31:0] acc_l = 32'h0;
   logic [31:0] acc_r = 32'h0;
   int vcyc = 0;
   int rise_cyc = 0;
   int prev_rise_cyc = 0;
   int lr_rise_cyc = 0;
   logic prev_lr = 1'b0;
   logic        snap_v = 1'b0;
   logic [31:0] snap_l = 32'h0;
   logic [31:0] snap_r = 32'h0;
   logic [31:0] snap_acc_l = 32'h0;

   i2s_adc_rx #(.DATA_WIDTH(24), .OUT_WIDTH(32)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .enable_i       (enable),
      .i2s_bclk_i     (bclk),
      .i2s_lrclk_i    (lrclk),
      .i2s_adcdat_i   (adcdat),
      .sample_left_o  (left),
      .sample_right_o (right),
      .sample_valid_o (valid),
      .sample_ready_i (ready),
      .overflow_o     (ovf),
      .frame_err_o    (ferr),
      .clear_flags_i  (clear)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected end of test sequence");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      logic        pv, pr;
      logic [31:0] pl, prr;
      pv = valid; pr = ready; pl = left; prr = right;
      @(posedge clk); #1;
      cyc++;
      if (pv && pr) begin acc_n++; acc_l = pl; acc_r = prr; end
      if (valid) vcyc++;
      if (valid && !pv) begin prev_rise_cyc = rise_cyc; rise_cyc = cyc; end
      if (lrclk && !prev_lr) lr_rise_cyc = cyc;
      prev_lr = lrclk;
   endtask

   task automatic half(input logic lr, input logic [23:0] w, input int nbits, input int first);
      for (int p = first; p < nbits; p++) begin
         for (int c = 0; c < 32; c++) begin
            lrclk  = lr;
            bclk   = (c >= 16);
            adcdat = (p < 24) ? w[23-p] : 1'b0;
            tick();
            if (p == first && c == 0) begin
               snap_v = valid; snap_l = left; snap_r = right; snap_acc_l = acc_l;
            end
         end
      end
   endtask

   task automatic frame(input logic [23:0] l, input logic [23:0] r);
      half(1'b1, l, 24, 0);
      half(1'b0, r, 24, 0);
   endtask

   task automatic do_reset(input logic lr);
      rst = 1'b1; lrclk = lr; bclk = 1'b0; adcdat = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; ready = 1'b0;
      repeat (4) tick();
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", valid); end
      checks++; if (left !== 32'h0) begin errors++; $display("FAIL reset_left: got %h expected 00000000", left); end
      checks++; if (right !== 32'h0) begin errors++; $display("FAIL reset_right: got %h expected 00000000", right); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %0b expected 0", ovf); end
      checks++; if (ferr !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %0b expected 0", ferr); end
   endtask

   task automatic test_nominal();
      do_reset(1'b0);
      ready = 1'b1; acc_n = 0; vcyc = 0;
      repeat (3) frame(24'hABCDEF, 24'h123456);
      half(1'b1, 24'hABCDEF, 24, 0);
      checks++; if (acc_n !== 3) begin errors++; $display("FAIL nom_pairs: got %0d expected 3", acc_n); end
      checks++; if (acc_l !== 32'hABCDEF00) begin errors++; $display("FAIL nom_left: got %h expected abcdef00", acc_l); end
      checks++; if (acc_r !== 32'h12345600) begin errors++; $display("FAIL nom_right: got %h expected 12345600", acc_r); end
      checks++; if (vcyc !== 3) begin errors++; $display("FAIL nom_valid_cycles: got %0d expected 3", vcyc); end
      checks++; if (rise_cyc - prev_rise_cyc !== 1536) begin errors++; $display("FAIL nom_period: got %0d expected 1536", rise_cyc - prev_rise_cyc); end
      checks++; if (rise_cyc !== lr_rise_cyc) begin errors++; $display("FAIL nom_latency: got cycle %0d expected %0d", rise_cyc, lr_rise_cyc); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL nom_ovf: got %0b expected 0", ovf); end
      checks++; if (ferr !== 1'b0) begin errors++; $display("FAIL nom_ferr: got %0b expected 0", ferr); end
   endtask

   task automatic test_mid_frame();
      int acc0;
      ready = 1'b1;
      do_reset(1'b1);
      acc0 = acc_n;
      half(1'b1, 24'hFFFFFF, 24, 12);
      half(1'b0, 24'h0F0F0F, 24, 0);
      frame(24'h800001, 24'h7FFFFE);
      half(1'b1, 24'h000000, 24, 0);
      checks++; if (acc_n - acc0 !== 1) begin errors++; $display("FAIL mid_pairs: got %0d expected 1", acc_n - acc0); end
      checks++; if (acc_l !== 32'h80000100) begin errors++; $display("FAIL mid_left: got %h expected 80000100", acc_l); end
      checks++; if (acc_r !== 32'h7FFFFE00) begin errors++; $display("FAIL mid_right: got %h expected 7ffffe00", acc_r); end
   endtask

   task automatic test_backpressure();
      int acc0;
      do_reset(1'b0);
      ready = 1'b0; acc0 = acc_n;
      frame(24'h111111, 24'h222222);
      frame(24'h333333, 24'h444444);
      half(1'b1, 24'h555555, 24, 0);
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL bp_valid_held: got %0b expected 1", valid); end
      checks++; if (left !== 32'h11111100) begin errors++; $display("FAIL bp_left_held: got %h expected 11111100", left); end
      checks++; if (right !== 32'h22222200) begin errors++; $display("FAIL bp_right_held: got %h expected 22222200", right); end
      checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL bp_ovf_set: got %0b expected 1", ovf); end
      checks++; if (ferr !== 1'b0) begin errors++; $display("FAIL bp_ferr: got %0b expected 0", ferr); end
      checks++; if (acc_n !== acc0) begin errors++; $display("FAIL bp_no_accept: got %0d expected %0d", acc_n, acc0); end
      ready = 1'b1;
      half(1'b0, 24'h666666, 24, 0);
      checks++; if (acc_n - acc0 !== 1) begin errors++; $display("FAIL bp_accept_count: got %0d expected 1", acc_n - acc0); end
      checks++; if (acc_l !== 32'h11111100) begin errors++; $display("FAIL bp_accept_left: got %h expected 11111100", acc_l); end
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL bp_valid_drop: got %0b expected 0", valid); end
      checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL bp_ovf_sticky: got %0b expected 1", ovf); end
      clear = 1'b1; tick(); clear = 1'b0; tick();
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL bp_ovf_clear: got %0b expected 0", ovf); end
   endtask

   task automatic test_accept_complete();
      int acc0;
      ready = 1'b0;
      half(1'b1, 24'h777777, 24, 0);
      checks++; if (left !== 32'h55555500) begin errors++; $display("FAIL ac_pair_c: got %h expected 55555500", left); end
      half(1'b0, 24'h888888, 24, 0);
      acc0 = acc_n;
      ready = 1'b1;
      half(1'b1, 24'h999999, 24, 0);
      checks++; if (snap_v !== 1'b1) begin errors++; $display("FAIL ac_valid_stays: got %0b expected 1", snap_v); end
      checks++; if (snap_l !== 32'h77777700) begin errors++; $display("FAIL ac_left_switch: got %h expected 77777700", snap_l); end
      checks++; if (snap_r !== 32'h88888800) begin errors++; $display("FAIL ac_right_switch: got %h expected 88888800", snap_r); end
      checks++; if (snap_acc_l !== 32'h55555500) begin errors++; $display("FAIL ac_first_accept: got %h expected 55555500", snap_acc_l); end
      checks++; if (acc_n - acc0 !== 2) begin errors++; $display("FAIL ac_accept_count: got %0d expected 2", acc_n - acc0); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ac_ovf: got %0b expected 0", ovf); end
   endtask

   task automatic test_short_half();
      int acc0;
      do_reset(1'b0);
      ready = 1'b1; acc0 = acc_n;
      half(1'b1, 24'hAAAAAA, 20, 0);
      half(1'b0, 24'hBBBBBB, 24, 0);
      checks++; if (ferr !== 1'b1) begin errors++; $display("FAIL sh_ferr: got %0b expected 1", ferr); end
      frame(24'h13579B, 24'h2468AC);
      half(1'b1, 24'h000000, 24, 0);
      checks++; if (acc_n - acc0 !== 1) begin errors++; $display("FAIL sh_pairs: got %0d expected 1", acc_n - acc0); end
      checks++; if (acc_l !== 32'h13579B00) begin errors++; $display("FAIL sh_left: got %h expected 13579b00", acc_l); end
      checks++; if (acc_r !== 32'h2468AC00) begin errors++; $display("FAIL sh_right: got %h expected 2468ac00", acc_r); end
   endtask

   task automatic test_reset_enable_mid();
      int acc0;
      do_reset(1'b0);
      ready = 1'b0;
      frame(24'h010203, 24'h040506);
      half(1'b1, 24'hC0FFEE, 24, 0);
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL rm_pending: got %0b expected 1", valid); end
      half(1'b0, 24'hBEEF01, 10, 0);
      rst = 1'b1; bclk = 1'b0; tick(); tick(); rst = 1'b0;
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rm_valid_zero: got %0b expected 0", valid); end
      checks++; if (left !== 32'h0) begin errors++; $display("FAIL rm_left_zero: got %h expected 00000000", left); end
      checks++; if (right !== 32'h0) begin errors++; $display("FAIL rm_right_zero: got %h expected 00000000", right); end
      frame(24'h6789AB, 24'hCDEF12);
      half(1'b1, 24'h000000, 24, 0);
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL rm_next_valid: got %0b expected 1", valid); end
      checks++; if (left !== 32'h6789AB00) begin errors++; $display("FAIL rm_next_left: got %h expected 6789ab00", left); end
      checks++; if (right !== 32'hCDEF1200) begin errors++; $display("FAIL rm_next_right: got %h expected cdef1200", right); end
      ready = 1'b1;
      half(1'b0, 24'h111111, 10, 0);
      acc0 = acc_n;
      enable = 1'b0; bclk = 1'b0; repeat (3) tick(); enable = 1'b1;
      half(1'b0, 24'h111111, 24, 10);
      half(1'b1, 24'h9ABCDE, 24, 0);
      checks++; if (acc_n !== acc0) begin errors++; $display("FAIL en_no_pair: got %0d expected %0d", acc_n, acc0); end
      half(1'b0, 24'hF01234, 24, 0);
      half(1'b1, 24'h000000, 24, 0);
      checks++; if (acc_n - acc0 !== 1) begin errors++; $display("FAIL en_pairs: got %0d expected 1", acc_n - acc0); end
      checks++; if (acc_l !== 32'h9ABCDE00) begin errors++; $display("FAIL en_left: got %h expected 9abcde00", acc_l); end
      checks++; if (acc_r !== 32'hF0123400) begin errors++; $display("FAIL en_right: got %h expected f0123400", acc_r); end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_mid_frame();
      test_backpressure();
      test_accept_complete();
      test_short_half();
      test_reset_enable_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
